lfsr_range_rng: RTL

//  Parametrised LFSR random source for game logic; successor to the fixed 8-bit PRNG.

---
 rtl/lfsr_range_rng.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/lfsr_range_rng.sv
// lfsr_range_rng: free-running Fibonacci LFSR with seed load, plus a request/valid
// draw port returning a uniform index in [0, RANGE-1] via rejection sampling.
module lfsr_range_rng #(
  parameter int               WIDTH        = 8,
  parameter int               RANGE        = 6,
  // Derived index width; do not override.
  parameter int               OUT_W        = (RANGE > 1) ? $clog2(RANGE) : 1,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(8'hA5),
  parameter int               MAX_TRIES    = 8,
  parameter bit               NO_REPEAT    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  input  logic             seed_load,
  input  logic             req,
  output logic             rnd_valid,
  output logic [OUT_W-1:0] rnd_idx,
  output logic             busy,
  output logic [WIDTH-1:0] lfsr_q
);

  // Parameter legality is enforced at elaboration time.
  generate
    if (WIDTH != 8 && WIDTH != 16 && WIDTH != 24 && WIDTH != 32) begin : g_bad_width
      $error("lfsr_range_rng: WIDTH must be 8, 16, 24 or 32");
    end
    if (RANGE < 1 || longint'(RANGE) > (longint'(1) << WIDTH)) begin : g_bad_range
      $error("lfsr_range_rng: RANGE must be in [1, 2**WIDTH]");
    end
    if (OUT_W != ((RANGE > 1) ? $clog2(RANGE) : 1)) begin : g_bad_out_w
      $error("lfsr_range_rng: OUT_W is derived and must not be overridden");
    end
    if (SEED_DEFAULT == '0) begin : g_bad_seed
      $error("lfsr_range_rng: SEED_DEFAULT must be nonzero");
    end
    if (MAX_TRIES < 1) begin : g_bad_tries
      $error("lfsr_range_rng: MAX_TRIES must be >= 1");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    DRAW
  } state_t;

  // Maximal-length tap sets as bit masks (tap n -> bit n-1).
  localparam logic [31:0] TAPS_32 =
    (WIDTH == 8)  ? 32'h0000_00B8 :
    (WIDTH == 16) ? 32'h0000_D008 :
    (WIDTH == 24) ? 32'h00E1_0000 :
                    32'h8020_0003;
  localparam logic [WIDTH-1:0] TAP_MASK = TAPS_32[WIDTH-1:0];

  localparam int               TRIES_W   = $clog2(MAX_TRIES + 1);
  localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);
  localparam logic [OUT_W:0]   RANGE_W   = (OUT_W + 1)'(RANGE);
  localparam logic [OUT_W-1:0] RANGE_LO  = OUT_W'(RANGE);
  localparam logic [OUT_W-1:0] RANGE_M1  = OUT_W'(RANGE - 1);
  localparam bit               NO_REPEAT_EFF = NO_REPEAT && (RANGE > 1);

  state_t               state_q, state_d;
  logic [TRIES_W-1:0]   tries_q, tries_d, tries_now;
  logic [OUT_W-1:0]     cand, idx_d, fallback_idx;
  logic                 out_of_range, is_repeat, reject, exhausted, deliver;
  logic                 last_valid;
  logic [WIDTH-1:0]     lfsr_shift;

  assign lfsr_shift = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAP_MASK)};

  // A nonzero state on a maximal LFSR never reaches zero; a zero seed is
  // replaced by the default so the register can never lock up.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED_DEFAULT;
    end else if (seed_load) begin
      lfsr_q <= (seed == '0) ? SEED_DEFAULT : seed;
    end else begin
      lfsr_q <= lfsr_shift;
    end
  end

  // Candidate evaluation on the current LFSR value.
  always_comb begin
    cand         = lfsr_q[OUT_W-1:0];
    out_of_range = ({1'b0, cand} >= RANGE_W);
    is_repeat    = NO_REPEAT_EFF && last_valid && (cand == rnd_idx);
    reject       = out_of_range || is_repeat;
    tries_now    = (state_q == IDLE) ? TRIES_W'(1) : tries_q + 1'b1;
    exhausted    = (tries_now == TRIES_MAX);
    // Fallback stays in range: cand < 2*RANGE, and a repeat is already < RANGE.
    if (out_of_range) begin
      fallback_idx = cand - RANGE_LO;
    end else if (cand == RANGE_M1) begin
      fallback_idx = '0;
    end else begin
      fallback_idx = cand + 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    deliver = 1'b0;
    idx_d   = cand;
    unique case (state_q)
      IDLE: begin
        if (req && !rnd_valid) begin
          if (!reject) begin
            deliver = 1'b1;
          end else if (exhausted) begin
            deliver = 1'b1;
            idx_d   = fallback_idx;
          end else begin
            state_d = DRAW;
            tries_d = tries_now;
          end
        end
      end
      DRAW: begin
        if (!reject) begin
          deliver = 1'b1;
          state_d = IDLE;
        end else if (exhausted) begin
          deliver = 1'b1;
          idx_d   = fallback_idx;
          state_d = IDLE;
        end else begin
          tries_d = tries_now;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tries_q    <= '0;
      rnd_valid  <= 1'b0;
      rnd_idx    <= '0;
      last_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      tries_q   <= tries_d;
      rnd_valid <= deliver;
      if (deliver) begin
        rnd_idx    <= idx_d;
        last_valid <= 1'b1;
      end
    end
  end

  assign busy = (state_q == DRAW);

endmodule
